// File: rtl/seg_scan_ctrl.sv
// Multiplexed N-digit 7-segment scan controller: valid/ready BCD load, leading-zero
// blanking with floating minus, per-digit point/blink, PWM brightness, ghost blanking.
module seg_scan_ctrl #(
   parameter int DIGITS         = 6,
   parameter int CLK_HZ         = 50_000_000,
   parameter int SCAN_HZ        = 1000,
   parameter int BLANK_CYC      = 16,
   parameter int BRIGHT_W       = 3,
   parameter int BLINK_FRAMES   = 250,
   parameter int SEL_ACTIVE_LOW = 1,
   parameter int SEG_ACTIVE_LOW = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  din_valid,
   output logic                  din_ready,
   input  logic [4*DIGITS-1:0]   din_bcd,
   input  logic [DIGITS-1:0]     din_point,
   input  logic                  din_sign,
   input  logic [DIGITS-1:0]     din_blink,
   input  logic                  en,
   input  logic                  lzb,
   input  logic [BRIGHT_W-1:0]   bright,
   output logic [DIGITS-1:0]     seg_sel,
   output logic [7:0]            seg_led,
   output logic                  frame_done
);

   localparam int DWELL_CYC = CLK_HZ / SCAN_HZ;
   localparam int SLOT      = (DWELL_CYC - BLANK_CYC) >> BRIGHT_W;
   localparam int CW        = $clog2(DWELL_CYC);
   localparam int DW        = $clog2(DIGITS);
   localparam int FW        = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   localparam logic [CW-1:0]     BLANK_LAST = CW'(BLANK_CYC - 1);
   localparam logic [CW-1:0]     DWELL_LAST = CW'(DWELL_CYC - 1);
   localparam logic [DW-1:0]     LAST_DIG   = DW'(DIGITS - 1);
   localparam logic [FW-1:0]     LAST_FRM   = FW'(BLINK_FRAMES - 1);
   localparam logic [DIGITS-1:0] SEL_OFF    = (SEL_ACTIVE_LOW != 0) ? '1 : '0;
   localparam logic [7:0]        SEG_OFF    = (SEG_ACTIVE_LOW != 0) ? '1 : '0;

   typedef enum logic {S_BLANK, S_ON} state_t;

   state_t               state, state_n;
   logic [CW-1:0]        cnt, cnt_n;
   logic [DW-1:0]        dig, dig_n;
   logic [BRIGHT_W-1:0]  bright_q;
   logic [FW-1:0]        frm_cnt;
   logic                 blink_ph;
   logic                 frame_start, frame_end;

   logic [4*DIGITS-1:0]  pend_bcd, disp_bcd;
   logic [DIGITS-1:0]    pend_pt, disp_pt, pend_blink, disp_blink;
   logic                 pend_sign, disp_sign;

   logic [DIGITS-1:0]    blanked, minus_pos;
   logic                 lz_run;
   logic [3:0]           code;
   logic                 dp_eff, drive;
   logic [31:0]          pwm_end;

   function automatic logic [6:0] seg7(input logic [3:0] c);
      case (c)
         4'd0:    seg7 = 7'h3F;
         4'd1:    seg7 = 7'h06;
         4'd2:    seg7 = 7'h5B;
         4'd3:    seg7 = 7'h4F;
         4'd4:    seg7 = 7'h66;
         4'd5:    seg7 = 7'h6D;
         4'd6:    seg7 = 7'h7D;
         4'd7:    seg7 = 7'h07;
         4'd8:    seg7 = 7'h7F;
         4'd9:    seg7 = 7'h6F;
         4'd11:   seg7 = 7'h40;
         default: seg7 = 7'h00;
      endcase
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_BLANK;
         cnt   <= '0;
         dig   <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         dig   <= dig_n;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt + 1'b1;
      dig_n   = dig;
      unique case (state)
         S_BLANK: if (cnt == BLANK_LAST) state_n = S_ON;
         S_ON: if (cnt == DWELL_LAST) begin
            state_n = S_BLANK;
            cnt_n   = '0;
            dig_n   = (dig == LAST_DIG) ? '0 : dig + 1'b1;
         end
      endcase
      frame_start = (state == S_BLANK) && (cnt == '0) && (dig == '0);
      frame_end   = (state == S_ON) && (cnt == DWELL_LAST) && (dig == LAST_DIG);
   end

   // Leading-zero run is accumulated from the top digit down; the minus lands on its lowest member.
   always_comb begin
      lz_run    = 1'b1;
      blanked   = '0;
      minus_pos = '0;
      for (int unsigned i = DIGITS - 1; i >= 1; i--) begin
         lz_run     = lz_run && (disp_bcd[4*i +: 4] == 4'd0) && !disp_pt[i];
         blanked[i] = lzb && lz_run;
      end
      for (int unsigned i = 1; i < DIGITS; i++)
         minus_pos[i] = disp_sign && blanked[i] && !blanked[i-1];

      code = disp_bcd[4*dig +: 4];
      if (blanked[dig])
         code = minus_pos[dig] ? 4'd11 : 4'd10;
      if (blink_ph && disp_blink[dig])
         code = 4'd10;
      dp_eff = disp_pt[dig] && (code <= 4'd9);

      pwm_end = 32'(BLANK_CYC) + (32'(bright_q) + 32'd1) * 32'(SLOT);
      drive   = en && (state == S_ON) && (32'(cnt) < pwm_end);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg_sel    <= SEL_OFF;
         seg_led    <= SEG_OFF;
         frame_done <= 1'b0;
         bright_q   <= '0;
         frm_cnt    <= '0;
         blink_ph   <= 1'b0;
      end else begin
         seg_sel    <= SEL_OFF ^ (drive ? (DIGITS'(1) << dig) : '0);
         seg_led    <= SEG_OFF ^ (drive ? {dp_eff, seg7(code)} : 8'h00);
         frame_done <= frame_end;
         if ((state == S_BLANK) && (cnt == BLANK_LAST))
            bright_q <= bright;
         if (frame_end) begin
            if (frm_cnt == LAST_FRM) begin
               frm_cnt  <= '0;
               blink_ph <= ~blink_ph;
            end else begin
               frm_cnt <= frm_cnt + 1'b1;
            end
         end
      end
   end

   // din_ready low doubles as the "pending word held" flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         din_ready  <= 1'b1;
         pend_bcd   <= '0;
         pend_pt    <= '0;
         pend_blink <= '0;
         pend_sign  <= 1'b0;
         disp_bcd   <= {DIGITS{4'hA}};
         disp_pt    <= '0;
         disp_blink <= '0;
         disp_sign  <= 1'b0;
      end else if (din_valid && din_ready) begin
         din_ready  <= 1'b0;
         pend_bcd   <= din_bcd;
         pend_pt    <= din_point;
         pend_blink <= din_blink;
         pend_sign  <= din_sign;
      end else if (!din_ready && frame_start) begin
         din_ready  <= 1'b1;
         disp_bcd   <= pend_bcd;
         disp_pt    <= pend_pt;
         disp_blink <= pend_blink;
         disp_sign  <= pend_sign;
      end
   end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl: per-frame capture of each digit's select time and pattern.
module tb_seg_scan_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        din_valid = 1'b0;
   logic        din_ready;
   logic [23:0] din_bcd = '0;
   logic [5:0]  din_point = '0;
   logic        din_sign = 1'b0;
   logic [5:0]  din_blink = '0;
   logic        en = 1'b1;
   logic        lzb = 1'b1;
   logic [2:0]  bright = 3'd7;
   logic [5:0]  seg_sel;
   logic [7:0]  seg_led;
   logic        frame_done;

   seg_scan_ctrl #(
      .DIGITS(6), .CLK_HZ(1000), .SCAN_HZ(100), .BLANK_CYC(2), .BRIGHT_W(3),
      .BLINK_FRAMES(2), .SEL_ACTIVE_LOW(1), .SEG_ACTIVE_LOW(1)
   ) dut (
      .clk(clk), .rst_n(rst_n), .din_valid(din_valid), .din_ready(din_ready),
      .din_bcd(din_bcd), .din_point(din_point), .din_sign(din_sign), .din_blink(din_blink),
      .en(en), .lzb(lzb), .bright(bright), .seg_sel(seg_sel), .seg_led(seg_led),
      .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [23:0] bcd;
      logic [5:0]  pt;
      logic        sign;
      logic        lzb;
      logic        en;
      logic [2:0]  bright;
      logic [47:0] leds;   // {d5,d4,d3,d2,d1,d0}, active-low
      int          cnt;
   } vec_t;

   int          n_chk = 0;
   int          n_fail = 0;
   int          got_cnt [6];
   int          got_first [6];
   logic [7:0]  got_led [6];
   int          idle_bad;
   int          fd_bad;

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   // Samples frame cycles first_k..60 after the frame_done cycle that opened the frame.
   task automatic capture(input int first_k);
      logic [5:0] sel;
      for (int d = 0; d < 6; d++) begin
         got_cnt[d] = 0; got_first[d] = -1; got_led[d] = 8'h00;
      end
      idle_bad = 0;
      fd_bad = 0;
      for (int k = first_k; k <= 60; k++) begin
         @(posedge clk); #1;
         sel = ~seg_sel;
         if (sel == 6'd0) begin
            if (seg_led != 8'hFF) idle_bad = 1;
         end else if ($onehot(sel)) begin
            for (int d = 0; d < 6; d++) if (sel[d]) begin
               if (got_first[d] < 0) got_first[d] = k;
               else if (got_led[d] != seg_led) idle_bad = 1;
               got_cnt[d]++;
               got_led[d] = seg_led;
            end
         end else begin
            idle_bad = 1;
         end
         if (frame_done != (k == 60)) fd_bad = 1;
      end
   endtask

   task automatic check_frame(input string nm, input logic [47:0] leds, input int cnt);
      chk({nm, " idle/glitch"}, idle_bad, 0);
      chk({nm, " frame_done period"}, fd_bad, 0);
      for (int d = 0; d < 6; d++) begin
         chk($sformatf("%s d%0d sel cycles", nm, d), got_cnt[d], cnt);
         if (cnt > 0) begin
            chk($sformatf("%s d%0d seg_led", nm, d), int'(got_led[d]), int'(leds[d*8 +: 8]));
            chk($sformatf("%s d%0d sel start", nm, d), got_first[d], 10*d + 3);
         end
      end
   endtask

   task automatic wait_fd();
      int found = 0;
      for (int k = 0; k < 200; k++) begin
         @(posedge clk); #1;
         if (frame_done) begin found = 1; break; end
      end
      chk("frame_done wait", found, 1);
   endtask

   task automatic load(input logic [23:0] bcd, input logic [5:0] pt, input logic sg, input logic [5:0] bl);
      int ok = 0;
      for (int k = 0; k < 200; k++) begin
         if (din_ready) begin ok = 1; break; end
         @(posedge clk); #1;
      end
      chk("load ready wait", ok, 1);
      din_bcd = bcd; din_point = pt; din_sign = sg; din_blink = bl; din_valid = 1'b1;
      @(posedge clk); #1;
      din_valid = 1'b0;
      chk("din_ready drop", int'(din_ready), 0);
   endtask

   vec_t vecs [9];
   logic [47:0] norm_leds, blink_leds;

   initial begin
      int fd_k, rdy_k;
      vecs[0] = '{24'h000042, 6'b000000, 1'b1, 1'b1, 1'b1, 3'd7, {8'hFF,8'hFF,8'hFF,8'hBF,8'h99,8'hA4}, 8};
      vecs[1] = '{24'h000100, 6'b010000, 1'b1, 1'b1, 1'b1, 3'd0, {8'hBF,8'h40,8'hC0,8'hF9,8'hC0,8'hC0}, 1};
      vecs[2] = '{24'h123456, 6'b000101, 1'b1, 1'b1, 1'b1, 3'd3, {8'hF9,8'hA4,8'hB0,8'h19,8'h92,8'h02}, 4};
      vecs[3] = '{24'h000007, 6'b000000, 1'b1, 1'b0, 1'b1, 3'd5, {8'hC0,8'hC0,8'hC0,8'hC0,8'hC0,8'hF8}, 6};
      vecs[4] = '{24'hFBA987, 6'b111111, 1'b0, 1'b1, 1'b1, 3'd7, {8'hFF,8'hBF,8'hFF,8'h10,8'h00,8'h78}, 8};
      vecs[5] = '{24'h000000, 6'b000000, 1'b1, 1'b1, 1'b1, 3'd1, {8'hFF,8'hFF,8'hFF,8'hFF,8'hBF,8'hC0}, 2};
      vecs[6] = '{24'h000042, 6'b000000, 1'b1, 1'b1, 1'b0, 3'd7, {8'hFF,8'hFF,8'hFF,8'hFF,8'hFF,8'hFF}, 0};
      vecs[7] = '{24'h000000, 6'b000100, 1'b0, 1'b1, 1'b1, 3'd6, {8'hFF,8'hFF,8'hFF,8'h40,8'hC0,8'hC0}, 7};
      vecs[8] = '{24'h000000, 6'b000000, 1'b1, 1'b0, 1'b1, 3'd2, {8'hC0,8'hC0,8'hC0,8'hC0,8'hC0,8'hC0}, 3};
      norm_leds  = {8'hFF,8'hFF,8'hFF,8'hBF,8'h99,8'hA4};
      blink_leds = {8'hFF,8'hFF,8'hFF,8'hBF,8'h99,8'hFF};

      // Reset values
      #17;
      chk("reset seg_sel", int'(seg_sel), 'h3F);
      chk("reset seg_led", int'(seg_led), 'hFF);
      chk("reset din_ready", int'(din_ready), 1);
      chk("reset frame_done", int'(frame_done), 0);
      @(negedge clk); rst_n = 1'b1;

      // Frame 0 shows the all-blank display register
      capture(1);
      check_frame("reset frame", {6{8'hFF}}, 8);

      // Blink: word lands in frame 2; phase off in frames 2-3 and 6-7
      load(24'h000042, 6'b000000, 1'b1, 6'b000001);
      wait_fd();
      for (int f = 2; f <= 7; f++) begin
         capture(1);
         check_frame($sformatf("blink f%0d", f), (f == 4 || f == 5) ? norm_leds : blink_leds, 8);
      end

      // Table-driven formatting / brightness / enable vectors
      for (int v = 0; v < 9; v++) begin
         lzb = vecs[v].lzb; en = vecs[v].en; bright = vecs[v].bright;
         load(vecs[v].bcd, vecs[v].pt, vecs[v].sign, 6'b000000);
         wait_fd();
         capture(1);
         check_frame($sformatf("vec%0d", v), vecs[v].leds, vecs[v].cnt);
      end
      en = 1'b1; lzb = 1'b1; bright = 3'd7;

      // Back-to-back words: second stalls until the frame boundary
      din_bcd = 24'h000042; din_point = '0; din_sign = 1'b1; din_blink = '0; din_valid = 1'b1;
      @(posedge clk); #1;
      chk("b2b first accepted", int'(din_ready), 0);
      din_bcd = 24'h123456; din_point = 6'b000101;
      fd_k = -1; rdy_k = -1;
      for (int k = 1; k <= 200; k++) begin
         @(posedge clk); #1;
         if (frame_done) fd_k = k;
         if (din_ready) begin rdy_k = k; break; end
      end
      chk("b2b stall length", rdy_k, 60);
      chk("b2b ready after boundary", rdy_k - fd_k, 1);
      @(posedge clk); #1;
      din_valid = 1'b0;
      chk("b2b second accepted", int'(din_ready), 0);
      capture(3);
      check_frame("b2b first word", vecs[0].leds, 8);
      capture(1);
      check_frame("b2b second word", vecs[2].leds, 8);
      chk("b2b ready restored", int'(din_ready), 1);

      // Asynchronous reset in digit 3's dwell discards the pending word
      load(24'h999999, 6'b111111, 1'b0, 6'b000000);
      repeat (34) @(posedge clk);
      #1;
      chk("mid-frame digit3 selected", int'(seg_sel), 'h37);
      chk("mid-frame digit3 pattern", int'(seg_led), 'hB0);
      #2 rst_n = 1'b0;
      #1;
      chk("async reset seg_sel", int'(seg_sel), 'h3F);
      chk("async reset seg_led", int'(seg_led), 'hFF);
      chk("async reset din_ready", int'(din_ready), 1);
      chk("async reset frame_done", int'(frame_done), 0);
      @(negedge clk); @(negedge clk); rst_n = 1'b1;
      capture(1);
      check_frame("post-reset f0", {6{8'hFF}}, 8);
      capture(1);
      check_frame("post-reset f1", {6{8'hFF}}, 8);
      chk("post-reset din_ready", int'(din_ready), 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, expected end of test");
      $fatal(1, "watchdog");
   end

endmodule
